fetch_ctrl_r32i: RTL and testbench

Multi-cycle fetch/issue sequencer for the RV32I core. Drives the instruction-memory request handshake using the address from the program-counter block. Hands each fetched word to the execute stage and waits for completion. Pulses the PC-advance enable once per retired instruction, so branch outcomes are applied only after execute has resolved them.

---
 rtl/fetch_ctrl_r32i.sv | 149 ++++++++++++++
 tb/tb_fetch_ctrl_r32i.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_r32i.sv
// Multi-cycle fetch/issue sequencer for the RV32I core: fetch, issue, wait for execute, advance PC.
// Optional fetch-ack timeout fault is compiled in with FETCH_TIMEOUT_EN.
module fetch_ctrl_r32i #(
    parameter int unsigned dataW = 32
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] ProgAddr,
    output logic             ImemReq,
    output logic [dataW-1:0] ImemAddr,
    input  logic             ImemAck,
    input  logic [dataW-1:0] ImemData,
    output logic [dataW-1:0] Instr,
    output logic             InstrValid,
    input  logic             ExecReady,
    input  logic             ExecDone,
    input  logic             Stall,
    output logic             PCEnable,
    output logic [31:0]      InstrCount,
    output logic             Fault,
    output logic [1:0]       FaultCause
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_ADVANCE,
        S_FAULT
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cause_nxt;
    logic       fetch_timeout;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    // Held at zero outside FETCH, so it is clear on every FETCH entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state != S_FETCH) begin
            wait_cnt <= '0;
        end else if (!ImemAck) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // The count reaches TIMEOUT at the end of this cycle; an ack in the same cycle wins.
    assign fetch_timeout = (state == S_FETCH) && !ImemAck && (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    assign fetch_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = FaultCause;
        case (state)
            S_IDLE: begin
                if (ProgAddr[1:0] != 2'b00) begin
                    state_nxt = S_FAULT;
                    cause_nxt = CAUSE_MISALIGN;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ImemAck) begin
                    state_nxt = S_ISSUE;
                end else if (fetch_timeout) begin
                    state_nxt = S_FAULT;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_ISSUE: begin
                if (ExecReady) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ExecDone) begin
                    state_nxt = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (!Stall) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Same-cycle pulse so the PC block updates on the edge that leaves ADVANCE;
    // IDLE then sees the new PC.
    assign PCEnable = (state == S_ADVANCE) && !Stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ImemReq    <= 1'b0;
            ImemAddr   <= '0;
            Instr      <= '0;
            InstrValid <= 1'b0;
            InstrCount <= '0;
            Fault      <= 1'b0;
            FaultCause <= 2'b00;
        end else begin
            ImemReq    <= (state_nxt == S_FETCH);
            InstrValid <= (state_nxt == S_ISSUE);
            Fault      <= (state_nxt == S_FAULT);
            FaultCause <= cause_nxt;
            if (state == S_IDLE && state_nxt == S_FETCH) begin
                ImemAddr <= ProgAddr;
            end
            if (state == S_FETCH && ImemAck) begin
                Instr <= ImemData;
            end
            if (PCEnable) begin
                InstrCount <= InstrCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl_r32i.sv
// Self-checking bench for fetch_ctrl_r32i: plays PC block, instruction memory and execute stage,
// and checks each instruction transaction against a transaction-level expectation.
module tb_fetch_ctrl_r32i;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ProgAddr = '0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck = 1'b0;
    logic [31:0] ImemData = '0;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        ExecReady = 1'b0;
    logic        ExecDone = 1'b0;
    logic        Stall = 1'b0;
    logic        PCEnable;
    logic [31:0] InstrCount;
    logic        Fault;
    logic [1:0]  FaultCause;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_count = '0;
    logic [31:0] exp_instr = '0;
    logic [31:0] pc = '0;

    fetch_ctrl_r32i dut (
        .clock      (clock),
        .reset      (reset),
        .ProgAddr   (ProgAddr),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemAck    (ImemAck),
        .ImemData   (ImemData),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .ExecReady  (ExecReady),
        .ExecDone   (ExecDone),
        .Stall      (Stall),
        .PCEnable   (PCEnable),
        .InstrCount (InstrCount),
        .Fault      (Fault),
        .FaultCause (FaultCause)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        ImemAck   = 1'b0;
        ImemData  = '0;
        ExecReady = 1'b0;
        ExecDone  = 1'b0;
        Stall     = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_req", ImemReq, 0);
        check("rst_addr", ImemAddr, 0);
        check("rst_instr", Instr, 0);
        check("rst_valid", InstrValid, 0);
        check("rst_pcen", PCEnable, 0);
        check("rst_count", InstrCount, 0);
        check("rst_fault", Fault, 0);
        check("rst_cause", FaultCause, 0);
    endtask

    // Called at a negedge; reset is asserted asynchronously and released on a later negedge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        clear_inputs();
        #1;
        check_reset_values();
        next_cycle();
        check_reset_values();
        reset     = 1'b1;
        exp_count = '0;
        exp_instr = '0;
    endtask

    // One full instruction, entered at a negedge with the design in IDLE.
    task automatic run_instr(input logic [31:0] addr, input logic [31:0] word,
                             input int ack_dly, input int rdy_dly, input int done_dly,
                             input int stall_n);
        ProgAddr = addr;
        clear_inputs();
        check("idle_req", ImemReq, 0);
        check("idle_pcen", PCEnable, 0);
        next_cycle();
        for (int i = 0; i <= ack_dly; i++) begin
            check("fetch_req", ImemReq, 1);
            check("fetch_addr", ImemAddr, addr);
            check("fetch_instr_hold", Instr, exp_instr);
            check("fetch_fault", Fault, 0);
            ProgAddr = $urandom;
            if (i == ack_dly) begin
                ImemAck  = 1'b1;
                ImemData = word;
            end else begin
                ImemAck  = 1'b0;
                ImemData = $urandom;
            end
            next_cycle();
        end
        exp_instr = word;
        for (int i = 0; i <= rdy_dly; i++) begin
            check("issue_valid", InstrValid, 1);
            check("issue_instr", Instr, exp_instr);
            check("issue_req", ImemReq, 0);
            ExecReady = (i == rdy_dly);
            ExecDone  = 1'($urandom);
            ImemAck   = 1'($urandom);
            ImemData  = $urandom;
            next_cycle();
        end
        for (int i = 0; i <= done_dly; i++) begin
            check("exec_valid", InstrValid, 0);
            check("exec_pcen", PCEnable, 0);
            check("exec_instr", Instr, exp_instr);
            ExecReady = 1'($urandom);
            ExecDone  = (i == done_dly);
            ImemAck   = 1'($urandom);
            ImemData  = $urandom;
            next_cycle();
        end
        ExecDone = 1'b0;
        ImemAck  = 1'b0;
        for (int i = 0; i <= stall_n; i++) begin
            Stall = (i < stall_n);
            #1;
            check("adv_pcen", PCEnable, !Stall);
            check("adv_count", InstrCount, exp_count);
            check("adv_req", ImemReq, 0);
            next_cycle();
        end
        Stall = 1'b0;
        exp_count = exp_count + 32'd1;
        check("retire_count", InstrCount, exp_count);
        check("retire_pcen", PCEnable, 0);
    endtask

    function automatic logic [31:0] next_pc(input logic [31:0] cur);
        if ($urandom_range(0, 3) == 0) begin
            return $urandom & 32'hFFFF_FFFC;
        end
        return cur + 32'd4;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clock);
        do_reset();

        // Basic handshakes, each response one cycle after its request.
        run_instr(32'h0, 32'h0051_0093, 1, 1, 1, 0);
        pc = 32'h4;
        // Minimum-latency instruction.
        run_instr(pc, 32'h00C5_8533, 0, 0, 0, 0);
        pc = next_pc(pc);
        // Ack delayed 5 cycles.
        run_instr(pc, $urandom, 5, 0, 0, 0);
        pc = next_pc(pc);
        // Stall held 3 cycles in ADVANCE.
        run_instr(pc, $urandom, 0, 0, 0, 3);
        pc = next_pc(pc);

        for (int n = 0; n < 20; n++) begin
            run_instr(pc, $urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            pc = next_pc(pc);
        end

`ifdef FETCH_TIMEOUT_EN
        // No ack: fault after 16 FETCH cycles.
        ProgAddr = pc;
        next_cycle();
        for (int i = 0; i < 16; i++) begin
            check("to_req", ImemReq, 1);
            check("to_fault_early", Fault, 0);
            ImemAck = 1'b0;
            next_cycle();
        end
        check("to_fault", Fault, 1);
        check("to_cause", FaultCause, 2);
        check("to_req_drop", ImemReq, 0);
        do_reset();
        // Ack in the 16th FETCH cycle wins over the timeout.
        run_instr(pc, $urandom, 15, 0, 0, 0);
        check("to_ack_nofault", Fault, 0);
`else
        // Without the timeout feature FETCH waits indefinitely.
        run_instr(pc, $urandom, 40, 0, 0, 0);
        check("long_wait_nofault", Fault, 0);
`endif
        pc = next_pc(pc);

        // Misaligned PC at IDLE faults without ever requesting.
        ProgAddr = 32'h0000_0042;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            check("mis_fault", Fault, 1);
            check("mis_cause", FaultCause, 1);
            check("mis_req", ImemReq, 0);
            check("mis_valid", InstrValid, 0);
            check("mis_pcen", PCEnable, 0);
            ImemAck   = 1'b1;
            ExecReady = 1'b1;
            ExecDone  = 1'b1;
            ProgAddr  = 32'h0;
            next_cycle();
        end
        do_reset();

        // Reset in the middle of FETCH drops the request without a clock edge.
        run_instr(32'h0000_0100, $urandom, 0, 0, 0, 0);
        ProgAddr = 32'h0000_0104;
        next_cycle();
        check("mid_req_before", ImemReq, 1);
        next_cycle();
        check("mid_req_hold", ImemReq, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_req_async", ImemReq, 0);
        check("mid_count", InstrCount, 0);
        @(negedge clock);
        reset     = 1'b1;
        exp_count = '0;
        exp_instr = '0;
        run_instr(32'h0000_0200, 32'hDEAD_BEEF, 1, 1, 1, 0);
        check("restart_count", InstrCount, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
